// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: default widths, the NOP encoding
// and the RUN/HALT state type.
package if_stage_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int ADDR_WIDTH_DEF = 8;
    localparam int CNT_WIDTH_DEF  = 16;
    localparam logic [15:0] NOP_INSTR_DEF = 16'h0000;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } if_state_t;

endpackage

// File: rtl/if_stage_pc_reg.sv
// Program counter and its next-PC priority mux: branch, stall, stop, jump, then sequential.
// While halted the PC is frozen regardless of any redirect.
module pc_reg #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  halted,
    input  logic                  stall,
    input  logic                  stop,
    input  logic                  jump,
    input  logic [ADDR_WIDTH-1:0] jump_addr,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    output logic [ADDR_WIDTH-1:0] pc
);

    logic [ADDR_WIDTH-1:0] pc_next;

    // A taken branch outranks the stall because the stalled ID instruction is on the wrong path.
    always_comb begin
        pc_next = pc + ADDR_WIDTH'(1);
        if (halted) begin
            pc_next = pc;
        end else if (branch_taken) begin
            pc_next = branch_target;
        end else if (stall || stop) begin
            pc_next = pc;
        end else if (jump) begin
            pc_next = jump_addr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= '0;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the IM address and fills the IF/ID register.
// A Stop instruction in decode parks the stage in HALT until reset.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR = DATA_WIDTH'(NOP_INSTR_DEF)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_IF_i,
    input  logic                  flush_IF_ID_i,
    input  logic                  Jump_i,
    input  logic [ADDR_WIDTH-1:0] jumpAddr_i,
    input  logic                  branch_taken_i,
    input  logic [ADDR_WIDTH-1:0] branch_target_i,
    input  logic                  Stop_i,
    output logic [ADDR_WIDTH-1:0] instruction_mem_addr_o,
    input  logic [DATA_WIDTH-1:0] instruction_mem_rD_i,
    output logic [ADDR_WIDTH-1:0] PCD_o,
    output logic [DATA_WIDTH-1:0] instrD_o,
    output logic                  halted_o,
    output logic [CNT_WIDTH-1:0]  fetch_count_o
);

    if_state_t state, state_next;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pcd_next;
    logic [DATA_WIDTH-1:0] instr_next;
    logic [CNT_WIDTH-1:0]  count_next;

    pc_reg #(.ADDR_WIDTH(ADDR_WIDTH)) u_pc_reg (
        .clk           (clk),
        .rst           (rst),
        .halted        (state == S_HALT),
        .stall         (stall_IF_i),
        .stop          (Stop_i),
        .jump          (Jump_i),
        .jump_addr     (jumpAddr_i),
        .branch_taken  (branch_taken_i),
        .branch_target (branch_target_i),
        .pc            (pc)
    );

    assign instruction_mem_addr_o = pc;

    // Same priority as the PC mux; every redirect or flush squashes IF/ID to a NOP at PC 0.
    always_comb begin
        state_next = state;
        pcd_next   = PCD_o;
        instr_next = instrD_o;
        count_next = fetch_count_o;
        if (state == S_RUN) begin
            if (branch_taken_i) begin
                pcd_next   = '0;
                instr_next = NOP_INSTR;
            end else if (stall_IF_i) begin
                pcd_next   = PCD_o;
            end else if (Stop_i) begin
                pcd_next   = '0;
                instr_next = NOP_INSTR;
                state_next = S_HALT;
            end else if (Jump_i || flush_IF_ID_i) begin
                pcd_next   = '0;
                instr_next = NOP_INSTR;
            end else begin
                pcd_next   = pc;
                instr_next = instruction_mem_rD_i;
                count_next = fetch_count_o + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_RUN;
            PCD_o         <= '0;
            instrD_o      <= NOP_INSTR;
            fetch_count_o <= '0;
        end else begin
            state         <= state_next;
            PCD_o         <= pcd_next;
            instrD_o      <= instr_next;
            fetch_count_o <= count_next;
        end
    end

    assign halted_o = (state == S_HALT);

endmodule
